// File: rtl/hf_fir_sequencer.sv
// High-band FIR sequencer: steps the coefficient ROM in lock-step with the sample-queue
// read burst, runs the left/right signed MACs, then scales and saturates one sample per burst.
module hf_fir_sequencer #(
   parameter int NUM_TAPS = 1021,
   parameter int ADDR_W   = 10,
   parameter int ACC_W    = 42
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sequencing,
   input  logic [15:0]       lft_in,
   input  logic [15:0]       rght_in,
   input  logic [15:0]       coef,
   output logic [ADDR_W-1:0] coef_addr,
   output logic [15:0]       lft_out,
   output logic [15:0]       rght_out,
   output logic              smpl_vld,
   output logic              busy
);

   // state | meaning
   // IDLE  | waiting for a rising sequencing edge; coef_addr held at 0
   // MAC   | burst in progress, one tap issued per sequencing-high cycle
   // FLUSH | all taps issued, draining the multiply/accumulate pipeline
   // OUT   | scaled, saturated result presented; smpl_vld pulses
   typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  TAPS_C    = CNT_W'(NUM_TAPS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-32768);

   state_t state, next_state;
   logic [CNT_W-1:0] tap_cnt;
   logic seq_d;
   logic start, issue, abort;
   logic v1, v2;
   logic signed [31:0] prod_l, prod_r;
   logic signed [ACC_W-1:0] acc_l, acc_r;

   function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      s = a >>> 15;
      if (s > MAX_V)
         s = MAX_V;
      else if (s < MIN_V)
         s = MIN_V;
      return s[15:0];
   endfunction

   always_comb begin
      next_state = state;
      start      = 1'b0;
      issue      = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (sequencing && !seq_d) begin
               start      = 1'b1;
               issue      = 1'b1;
               next_state = MAC;
            end
         end
         MAC: begin
            if (sequencing) begin
               issue = (tap_cnt < TAPS_C);
            end else if (tap_cnt >= TAPS_C) begin
               next_state = FLUSH;
            end else begin
               abort      = 1'b1;
               next_state = IDLE;
            end
         end
         FLUSH: begin
            if (!v1 && !v2)
               next_state = OUT;
         end
         OUT: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      coef_addr = '0;
      if (state != IDLE)
         coef_addr = (tap_cnt >= TAPS_C) ? LAST_ADDR : tap_cnt[ADDR_W-1:0];
   end

   // busy covers the burst-start cycle, which is still spent in IDLE
   assign busy     = (state != IDLE) || start;
   assign smpl_vld = (state == OUT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         seq_d   <= 1'b0;
         tap_cnt <= '0;
      end else begin
         state <= next_state;
         seq_d <= sequencing;
         if (next_state == IDLE)
            tap_cnt <= '0;
         else if (issue)
            tap_cnt <= tap_cnt + 1'b1;
      end
   end

   // v1: ROM word and samples for a tap are valid; v2: its products are registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         prod_l <= '0;
         prod_r <= '0;
         acc_l  <= '0;
         acc_r  <= '0;
      end else begin
         v1 <= issue;
         v2 <= v1 && !abort;
         if (v1) begin
            prod_l <= $signed(coef) * $signed(lft_in);
            prod_r <= $signed(coef) * $signed(rght_in);
         end
         if (start) begin
            acc_l <= '0;
            acc_r <= '0;
         end else if (v2 && !abort) begin
            acc_l <= acc_l + ACC_W'(prod_l);
            acc_r <= acc_r + ACC_W'(prod_r);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_out  <= '0;
         rght_out <= '0;
      end else if (state == FLUSH && next_state == OUT) begin
         lft_out  <= sat16(acc_l);
         rght_out <= sat16(acc_r);
      end
   end

endmodule

// File: tb/tb_hf_fir_sequencer.sv
// Scoreboard bench for hf_fir_sequencer: bursts push expected outputs, a monitor
// pops and checks them whenever smpl_vld pulses.
module tb_hf_fir_sequencer;

   localparam int NUM_TAPS = 1021;
   localparam int ADDR_W   = 10;
   localparam int ACC_W    = 42;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sequencing = 1'b0;
   logic [15:0] lft_in = '0;
   logic [15:0] rght_in = '0;
   logic [15:0] coef = '0;
   logic [ADDR_W-1:0] coef_addr;
   logic [15:0] lft_out, rght_out;
   logic smpl_vld, busy;

   hf_fir_sequencer #(.NUM_TAPS(NUM_TAPS), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .sequencing(sequencing),
      .lft_in(lft_in), .rght_in(rght_in), .coef(coef),
      .coef_addr(coef_addr), .lft_out(lft_out), .rght_out(rght_out),
      .smpl_vld(smpl_vld), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int l;
      int r;
      int cyc;
   } exp_t;
   exp_t sb[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int max_addr = 0;
   int rom_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int rom_val(int mode, int a);
      case (mode)
         0: return a + 1;
         1: return 32;
         default: return 32767;
      endcase
   endfunction

   always @(posedge clk) coef <= 16'(rom_val(rom_mode, int'(coef_addr)));

   function automatic int samp_l(int mode, int k);
      case (mode)
         0: return (k == 0) ? 16384 : 0;
         1: return 1000;
         2: return 32767;
         default: return -1;
      endcase
   endfunction

   function automatic int samp_r(int mode, int k);
      case (mode)
         0: return (k == 0) ? -16384 : 0;
         1: return 1000;
         2: return -32768;
         default: return 7;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (int'(coef_addr) > max_addr) max_addr = int'(coef_addr);
      if (rst_n && smpl_vld) begin
         if (sb.size() == 0) begin
            check("unexpected_smpl_vld", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("lft_out", int'($signed(lft_out)), e.l);
            check("rght_out", int'($signed(rght_out)), e.r);
            check("latency_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic run_burst(input int taps, input int extra, input int smode, input int rmode,
                            input bit do_rst, input bit expect_out, input int exp_l, input int exp_r);
      int total, start, addr_bad, busy_cnt, k, ea;
      exp_t e;
      total = taps + extra;
      addr_bad = 0;
      busy_cnt = 0;
      rom_mode = rmode;
      @(negedge clk);
      start = cyc;
      if (expect_out) begin
         e.l = exp_l;
         e.r = exp_r;
         e.cyc = start + ((extra <= 1) ? 1024 : 1023 + extra);
         sb.push_back(e);
      end
      for (int t = 0; t <= total; t++) begin
         if (t > 0) @(negedge clk);
         if (do_rst && t == taps) begin
            rst_n = 1'b0;
            sequencing = 1'b0;
            lft_in = '0;
            rght_in = '0;
            break;
         end
         sequencing = (t < total);
         k = t - 1;
         if (k >= 0 && k < taps) begin
            lft_in = 16'(samp_l(smode, k));
            rght_in = 16'(samp_r(smode, k));
         end else begin
            lft_in = '0;
            rght_in = '0;
         end
         #1;
         if (t < total) begin
            ea = (t < NUM_TAPS) ? t : NUM_TAPS - 1;
            if (int'(coef_addr) != ea) addr_bad++;
         end
         if (busy) busy_cnt++;
      end
      if (do_rst) begin
         repeat (2) @(negedge clk);
         check("rst_lft_out", int'(lft_out), 0);
         check("rst_rght_out", int'(rght_out), 0);
         check("rst_coef_addr", int'(coef_addr), 0);
         check("rst_busy", int'(busy), 0);
         rst_n = 1'b1;
         repeat (3) @(negedge clk);
      end else begin
         repeat (10) begin
            @(negedge clk);
            if (busy) busy_cnt++;
         end
         if (!expect_out) begin
            check("abort_lft_hold", int'($signed(lft_out)), exp_l);
            check("abort_busy", int'(busy), 0);
            check("abort_coef_addr", int'(coef_addr), 0);
         end
         if (taps == NUM_TAPS && extra == 0)
            check("busy_cycles", busy_cnt, 1025);
      end
      check("addr_sequence_errors", addr_bad, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_lft_out", int'(lft_out), 0);
      check("reset_rght_out", int'(rght_out), 0);
      check("reset_smpl_vld", int'(smpl_vld), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_coef_addr", int'(coef_addr), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      run_burst(NUM_TAPS, 0, 0, 0, 1'b0, 1'b1, 0, -1);           // impulse
      run_burst(NUM_TAPS, 0, 1, 1, 1'b0, 1'b1, 997, 997);        // DC gain
      run_burst(NUM_TAPS, 0, 2, 2, 1'b0, 1'b1, 32767, -32768);   // saturation
      run_burst(NUM_TAPS, 0, 3, 0, 1'b0, 1'b1, -16, 111);        // negative sum, floor rounding
      run_burst(NUM_TAPS, 0, 1, 1, 1'b0, 1'b1, 997, 997);
      run_burst(500, 0, 1, 1, 1'b0, 1'b0, 997, 997);             // aborted burst
      run_burst(NUM_TAPS, 0, 1, 1, 1'b0, 1'b1, 997, 997);
      run_burst(600, 0, 1, 1, 1'b1, 1'b0, 0, 0);                 // reset mid-burst
      run_burst(NUM_TAPS, 0, 1, 1, 1'b0, 1'b1, 997, 997);
      run_burst(NUM_TAPS, 3, 1, 1, 1'b0, 1'b1, 997, 997);        // extra sequencing cycles

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      check("max_coef_addr_ok", int'(max_addr <= NUM_TAPS - 1), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hf_fir_sequencer.md
Name: hf_fir_sequencer

Overview:
Controller and MAC datapath that consumes the high-frequency circular sample queue's read burst and produces one high-band FIR output sample per burst for each channel. Steps the coefficient ROM address in lock-step with the queue read sequence, runs two signed multiply-accumulates (left and right), then scales and saturates. Sits between the high-frequency sample queue (which supplies `sequencing`, `lft_in`, `rght_in`) and the band-gain/mixer stage.

Parameters:
NUM_TAPS, 1021, products per burst; equals the queue read-burst length.
ADDR_W, 10, coefficient ROM address width; ceil(log2(NUM_TAPS)).
ACC_W, 42, accumulator width in bits; sign-extended, no wrap for NUM_TAPS full-scale products.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sequencing  input  1  queue read-burst active; high for one cycle per tap
lft_in  input  16  signed left sample from queue; valid the cycle after the matching sequencing-high cycle
rght_in  input  16  signed right sample; same timing as lft_in
coef  input  16  signed Q1.15 coefficient from synchronous ROM; 1-cycle read latency
coef_addr  output  ADDR_W  coefficient ROM address
lft_out  output  16  signed filtered left sample; held between updates
rght_out  output  16  signed filtered right sample; held between updates
smpl_vld  output  1  one-cycle pulse when lft_out and rght_out update
busy  output  1  high from the first sequencing-high cycle until the smpl_vld cycle, inclusive

Behaviour:
Clock and reset:
- Clock is clk.
- Reset is rst_n: asynchronous, active-low.
- Reset values: state IDLE; coef_addr=0; tap counter=0; both accumulators=0; pipeline registers=0; lft_out=0; rght_out=0; smpl_vld=0; busy=0.

States: IDLE, MAC, FLUSH, OUT.
- IDLE:
  - coef_addr=0.
  - On sequencing=1 (call this cycle 0): clear both accumulators, go to MAC, tap counter becomes 1.
  - coef_addr shows the tap counter, so it steps 0,1,2,... on successive sequencing-high cycles.
- MAC:
  - Each cycle with sequencing=1: increment the tap counter.
  - Tap counter saturates at NUM_TAPS; coef_addr never exceeds NUM_TAPS-1.
  - When NUM_TAPS taps have been issued and sequencing=0: go to FLUSH.
  - If sequencing=0 before NUM_TAPS taps have been issued (aborted burst):
    - go to IDLE;
    - no smpl_vld;
    - outputs keep their previous values;
    - in-flight products are discarded.
  - sequencing=1 beyond NUM_TAPS taps is ignored (no extra accumulation).
- Pipeline per tap k, issued in cycle k:
  - cycle k+1: coef(k), lft_in(k) and rght_in(k) are valid; 16x16 signed products registered (32-bit).
  - cycle k+2: products sign-extended to ACC_W and added to the accumulators.
- FLUSH: wait until the last product (k=NUM_TAPS-1) has been accumulated, then go to OUT.
- OUT:
  - Output = (acc >>> 15), saturated to [-32768, 32767].
  - lft_out and rght_out load this value.
  - smpl_vld=1 for exactly one cycle; then go to IDLE.
- Latency: smpl_vld is high in cycle NUM_TAPS+3, counted from cycle 0.
- Back-to-back bursts: a sequencing=1 arriving while in OUT or FLUSH is not a valid burst start. Only a rising sequencing seen in IDLE starts a burst. Upstream guarantees at least 2 idle cycles between bursts.
- busy is 1 in MAC, FLUSH and OUT; 0 in IDLE.
- Reset mid-burst: everything returns to reset values immediately. The next burst starts cleanly from IDLE.
- Arithmetic rules:
  - Products and accumulation are two's-complement.
  - Rounding is truncation, toward negative infinity.
  - Saturation is applied only at the output, never to the accumulator.

Test Plan:
- Impulse: ROM coef[i]=i+1; lft_in=16384 on tap 0, else 0; rght_in=-16384 on tap 0, else 0; NUM_TAPS-cycle burst -> lft_out=0, rght_out=-1 (16384*1>>>15 = 0; -16384>>>15 = -1). smpl_vld pulse exactly in cycle 1024.
- DC gain: coef[i]=32 for all i; lft_in=rght_in=1000 constant -> both outputs = (1000*32*1021)>>>15 = 997. busy high for cycles 0..1024.
- Saturation: coef[i]=32767; lft_in=32767 -> lft_out=32767. rght_in=-32768 -> rght_out=-32768. Accumulator shows no wrap.
- Aborted burst: first complete burst gives lft_out=997; second burst has sequencing drop after 500 taps -> no smpl_vld, lft_out stays 997, state returns to IDLE, coef_addr=0. A following full burst produces correct output.
- Reset mid-burst: assert rst_n=0 at tap 600 for 2 cycles -> all outputs 0, coef_addr=0. Next full burst matches the DC-gain result.
- Address sweep and extra cycles: log coef_addr across a burst -> strictly 0..1020 in order. Extend sequencing 3 extra cycles -> output unchanged (997); coef_addr never exceeds 1020.
